reaction_ctrl: RTL and testbench
================================

REACTION_CTRL -- requirements
Module: reaction_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000: clk cycles per 1 ms tick.
REQ-002 Parameter MIN_DELAY_MS, default 1000: fixed part of the random pre-go delay, in ms.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 btn  input  1  raw player button, asynchronous to clk, active-high.
REQ-006 show_best  input  1  selects the best-time display; used only with BEST_TIME_EN.
REQ-007 value  output  14  ms value to the 7-segment driver, range 0..9999.
REQ-008 show_error  output  1  requests the "Err" display.
REQ-009 led  output  1  go lamp, high only in GO.
REQ-010 round_done  output  1  one-cycle pulse when a round ends in RESULT or ERROR.

Function
REQ-011 btn SHALL pass through a 2-flop synchronizer and then a rising-edge detector.
- The result is btn_rise, one cycle wide.
- A btn level first sampled at edge k SHALL change the state at edge k+2.
REQ-012 A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) SHALL advance every clk cycle in every state.
REQ-013 A ms prescaler SHALL count 0..TICK_DIV-1 and assert tick on its terminal count.
- The prescaler clears on entry to WAIT and on entry to GO.
REQ-014 The state machine SHALL have the states IDLE, WAIT, GO, RESULT and ERROR.
REQ-015 IDLE: on btn_rise go to WAIT and load delay_ms = MIN_DELAY_MS + lfsr[9:0], 16-bit unsigned.
REQ-016 WAIT: each tick decrements delay_ms.
- tick with delay_ms==1 -> GO, and ms_count is cleared to 0.
REQ-017 WAIT: btn_rise -> ERROR (false start).
- btn_rise takes priority over a simultaneous terminal tick.
REQ-018 GO: led=1; each tick increments ms_count (14 bits).
REQ-019 GO: btn_rise -> RESULT and latch result = ms_count.
- If tick and btn_rise occur in the same cycle, the latched result is the pre-increment ms_count.
REQ-020 GO: tick with ms_count==9999 -> RESULT with result = 9999 (timeout); ms_count SHALL never exceed 9999.
REQ-021 RESULT: value = result, show_error=0; btn_rise -> WAIT with a new delay load, as in REQ-015.
REQ-022 ERROR: show_error=1, value=0; btn_rise -> IDLE.
REQ-023 value SHALL be 0 in IDLE, WAIT and GO.
REQ-024 led SHALL be 0 in every state except GO.
REQ-025 round_done SHALL pulse on the cycle after entry to RESULT or ERROR.
REQ-026 All outputs SHALL be registered.
- There is no combinational path from btn or show_best to any output.
- value/show_error/led update one cycle after the state change.

Reset
REQ-027 While reset is high:
- state=IDLE, value=0, show_error=0, led=0, round_done=0.
- ms_count=0, delay_ms=0, prescaler=0, synchronizer flops=0, LFSR=16'hACE1.
REQ-028 Reset asserted in any state, including mid-GO or mid-WAIT, SHALL abort the round with no round_done pulse.
REQ-029 After reset release, a btn already high SHALL NOT generate btn_rise; the btn edge flop resets to 0 and btn_rise needs a low-to-high transition after sync.

Configuration
REQ-030 Macro BEST_TIME_EN SHALL compile in a 14-bit best register.
- best resets to 9999.
- best updates to result on entry to RESULT when result < best; timeouts never lower best.
REQ-031 With BEST_TIME_EN defined:
- In IDLE or RESULT with show_best=1, value = best.
- show_best is ignored in other states.
REQ-032 Without BEST_TIME_EN:
- The best register is absent.
- show_best is unused.
- value follows REQ-021 to REQ-023 only.

Verification (TICK_DIV=4, MIN_DELAY_MS=2, LFSR forced-known via seed)
REQ-033 Reset with btn held high -> value=0, led=0, show_error=0; no WAIT entry until btn goes low then high.
REQ-034 Press in IDLE, wait for led=1, press after 37 ticks -> value=37, led=0, round_done one pulse, show_error=0.
REQ-035 Press during WAIT -> show_error=1, value=0, led never 1; next press -> IDLE, show_error=0.
REQ-036 No press in GO -> after 9999 ticks value=9999, state RESULT, ms_count never reads 10000.
REQ-037 BEST_TIME_EN: rounds of 50, 30, 80 ms, then show_best=1 in RESULT -> value=30; show_best=0 -> value=80.
REQ-038 Assert reset mid-GO at ms_count=500 -> led=0, value=0 on the same cycle, state IDLE, no round_done.

Source files
------------

// File: rtl/reaction_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : reaction_ctrl                                                 |
// | Purpose  : Reaction-time game controller: random pre-go delay, ms timer, |
// |            false-start detection. Define BEST_TIME_EN for best-time.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module reaction_ctrl #(
  parameter int TICK_DIV     = 50000,
  parameter int MIN_DELAY_MS = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn,
  input  logic        show_best,
  output logic [13:0] value,
  output logic        show_error,
  output logic        led,
  output logic        round_done
);

  localparam logic [15:0] c_lfsr_seed  = 16'hACE1;
  localparam logic [13:0] c_ms_max     = 14'd9999;
  localparam logic [15:0] c_min_delay  = 16'(MIN_DELAY_MS);
  localparam int          c_presc_w    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_GO     = 3'd2,
    S_RESULT = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t                 r_state, w_state_next;
  logic                   r_sync1, r_sync2, r_btn_prev, r_armed;
  logic [1:0]             r_fill;
  logic [15:0]            r_lfsr;
  logic [c_presc_w-1:0]   r_presc;
  logic [15:0]            r_delay, w_delay_next;
  logic [13:0]            r_ms, w_ms_next;
  logic [13:0]            r_result, w_result_next;
  logic [13:0]            r_value, w_value_next;
  logic                   r_show_error, r_led, r_round_done, r_entered;
  logic                   w_btn_rise, w_tick, w_presc_clr, w_lfsr_fb;
  logic [15:0]            w_delay_load;

  // A button already held across reset must first be seen low (after the
  // synchronizer has filled) before any rising edge is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_btn_prev <= 1'b0;
      r_fill     <= 2'b00;
      r_armed    <= 1'b0;
    end else begin
      r_sync1    <= btn;
      r_sync2    <= r_sync1;
      r_btn_prev <= r_sync2;
      r_fill     <= {r_fill[0], 1'b1};
      if (r_fill[1] && !r_sync2) r_armed <= 1'b1;
    end
  end

  assign w_btn_rise   = r_sync2 & ~r_btn_prev & r_armed;
  assign w_lfsr_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_tick       = (r_presc == c_presc_last);
  assign w_delay_load = c_min_delay + {6'd0, r_lfsr[9:0]};
  assign w_presc_clr  = (w_state_next != r_state) &&
                        ((w_state_next == S_WAIT) || (w_state_next == S_GO));

  always_comb begin
    w_state_next  = r_state;
    w_delay_next  = r_delay;
    w_ms_next     = r_ms;
    w_result_next = r_result;
    case (r_state)
      S_IDLE: begin
        if (w_btn_rise) begin
          w_state_next = S_WAIT;
          w_delay_next = w_delay_load;
        end
      end
      S_WAIT: begin
        if (w_btn_rise) begin
          w_state_next = S_ERROR;
        end else if (w_tick) begin
          w_delay_next = r_delay - 16'd1;
          if (r_delay <= 16'd1) begin
            w_state_next = S_GO;
            w_ms_next    = '0;
          end
        end
      end
      S_GO: begin
        if (w_btn_rise) begin
          w_state_next  = S_RESULT;
          w_result_next = r_ms;
        end else if (w_tick) begin
          if (r_ms == c_ms_max) begin
            w_state_next  = S_RESULT;
            w_result_next = c_ms_max;
          end else begin
            w_ms_next = r_ms + 14'd1;
          end
        end
      end
      S_RESULT: begin
        if (w_btn_rise) begin
          w_state_next = S_WAIT;
          w_delay_next = w_delay_load;
        end
      end
      S_ERROR: begin
        if (w_btn_rise) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_lfsr   <= c_lfsr_seed;
      r_presc  <= '0;
      r_delay  <= '0;
      r_ms     <= '0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_next;
      r_lfsr   <= {r_lfsr[14:0], w_lfsr_fb};
      r_presc  <= (w_presc_clr || w_tick) ? '0 : r_presc + 1'b1;
      r_delay  <= w_delay_next;
      r_ms     <= w_ms_next;
      r_result <= w_result_next;
    end
  end

`ifdef BEST_TIME_EN
  logic [13:0] r_best;

  // Only a real press lowers best; a timeout result is never a record.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_best <= c_ms_max;
    end else if ((r_state == S_GO) && w_btn_rise && (r_ms < r_best)) begin
      r_best <= r_ms;
    end
  end
`else
  logic w_unused_show_best;
  assign w_unused_show_best = show_best;
`endif

  always_comb begin
    w_value_next = '0;
    if (r_state == S_RESULT) w_value_next = r_result;
`ifdef BEST_TIME_EN
    if (show_best && ((r_state == S_IDLE) || (r_state == S_RESULT))) w_value_next = r_best;
`endif
  end

  // Outputs follow the registered state, so they lag a transition by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_value      <= '0;
      r_show_error <= 1'b0;
      r_led        <= 1'b0;
      r_entered    <= 1'b0;
      r_round_done <= 1'b0;
    end else begin
      r_value      <= w_value_next;
      r_show_error <= (r_state == S_ERROR);
      r_led        <= (r_state == S_GO);
      r_entered    <= (w_state_next != r_state);
      r_round_done <= r_entered && ((r_state == S_RESULT) || (r_state == S_ERROR));
    end
  end

  assign value      = r_value;
  assign show_error = r_show_error;
  assign led        = r_led;
  assign round_done = r_round_done;

endmodule
`default_nettype wire

// File: tb/tb_reaction_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_reaction_ctrl                                              |
// | Purpose  : Directed self-checking bench for reaction_ctrl                |
// |            (TICK_DIV=4, MIN_DELAY_MS=2).                                 |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_reaction_ctrl;

  logic        clk;
  logic        reset;
  logic        btn;
  logic        show_best;
  logic [13:0] value;
  logic        show_error;
  logic        led;
  logic        round_done;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_delay = 0;
  logic [15:0] m_lfsr;

  reaction_ctrl #(.TICK_DIV(4), .MIN_DELAY_MS(2)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .btn        (btn),
    .show_best  (show_best),
    .value      (value),
    .show_error (show_error),
    .led        (led),
    .round_done (round_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR, stepped alongside the design from the same seed.
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic check(input string tag, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Press for two cycles; the model value at release is the one loaded into delay_ms.
  task automatic press();
    btn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    exp_delay = 2 + int'(m_lfsr[9:0]);
    btn = 1'b0;
  endtask

  // led rises 4*delay+1 edges after the WAIT-entry edge.
  task automatic wait_go(input string tag);
    int cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!led && cnt < 4200);
    check(tag, cnt, 4 * exp_delay + 2);
  endtask

  task automatic finish_round(input string tag, input int gap, input int exp_val);
    int pulses = 0;
    repeat (gap) @(negedge clk);
    press();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (round_done) pulses++;
    end
    check({tag, "_done"}, pulses, 1);
    check({tag, "_value"}, int'(value), exp_val);
    check({tag, "_led"}, int'(led), 0);
    check({tag, "_err"}, int'(show_error), 0);
  endtask

  initial begin
    int pulses;
    int led_seen;
    int cnt;
    int max_val;

    reset = 1'b1;
    btn = 1'b1;
    show_best = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_value", int'(value), 0);
    check("rst_led", int'(led), 0);
    check("rst_err", int'(show_error), 0);
    check("rst_done", int'(round_done), 0);

    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("hold_led", int'(led), 0);
    check("hold_err", int'(show_error), 0);
    btn = 1'b0;
    repeat (5) @(negedge clk);

    press();
    wait_go("wait1");
    finish_round("r37", 146, 37);

    press();
    wait_go("wait2");
    finish_round("r9_tick_same_cycle", 36, 9);

    // False start: second press lands inside the minimum 2 ms WAIT.
    press();
    repeat (3) @(negedge clk);
    press();
    pulses = 0;
    led_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (round_done) pulses++;
      if (led) led_seen = 1;
    end
    check("fs_done", pulses, 1);
    check("fs_err", int'(show_error), 1);
    check("fs_value", int'(value), 0);
    check("fs_led", led_seen, 0);

    press();
    repeat (4) @(negedge clk);
    check("idle_err", int'(show_error), 0);
    check("idle_value", int'(value), 0);

    // Timeout: result arrives on the 10000th tick, round_done one edge later.
    press();
    wait_go("wait3");
    cnt = 0;
    max_val = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (int'(value) > max_val) max_val = int'(value);
    end while (!round_done && cnt < 41000);
    check("to_cycles", cnt, 40000);
    check("to_value", int'(value), 9999);
    check("to_led", int'(led), 0);
    check("to_err", int'(show_error), 0);
    check("to_max", max_val, 9999);

    // Reset in the middle of GO.
    press();
    wait_go("wait4");
    repeat (2000) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_led", int'(led), 0);
    check("mid_value", int'(value), 0);
    pulses = 0;
    repeat (3) @(negedge clk) if (round_done) pulses++;
    reset = 1'b0;
    repeat (10) @(negedge clk) if (round_done) pulses++;
    check("mid_no_done", pulses, 0);
    press();
    wait_go("wait5");
    finish_round("r12", 46, 12);

`ifdef BEST_TIME_EN
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    show_best = 1'b1;
    repeat (3) @(negedge clk);
    check("best_init", int'(value), 9999);
    show_best = 1'b0;
    repeat (3) @(negedge clk);
    press();
    wait_go("bwait1");
    finish_round("b50", 198, 50);
    press();
    wait_go("bwait2");
    finish_round("b30", 118, 30);
    press();
    wait_go("bwait3");
    finish_round("b80", 318, 80);
    show_best = 1'b1;
    repeat (3) @(negedge clk);
    check("best_show", int'(value), 30);
    show_best = 1'b0;
    repeat (3) @(negedge clk);
    check("best_hide", int'(value), 80);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
